bus_xfer_ctrl: RTL and testbench
================================

// Module: bus_xfer_ctrl
// PURPOSE
//  Downstream stage of the 4-master round-robin arbiter. Consumes the arbiter's
//  comcyc and encoded gnt[1:0], latches the owning master, and multiplexes that
//  master's request onto a single shared slave bus.
//  Runs a registered stb/ack handshake with the slave, routes ack/read data back
//  to the owner, and aborts a stalled transfer with a bus error after a fixed
//  timeout.
// PARAMETERS
//  AW         8   address width per master and on the slave bus
//  DW         8   data width (write and read)
//  TO_CYCLES  16  cycles s_stb may stay high without s_ack before error (>=2)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous, active-low reset
//  comcyc     in   1     arbiter: bus owned by master gnt
//  gnt        in   2     arbiter: encoded owner index, valid while comcyc=1
//  m_stb      in   4     per-master transfer request; held until m_ack/m_err
//  m_we       in   4     per-master write enable (1=write, 0=read)
//  m_adr      in   4*AW  master i address at [i*AW +: AW]
//  m_dat_w    in   4*DW  master i write data at [i*DW +: DW]
//  m_ack      out  4     one-cycle completion pulse to owner
//  m_err      out  4     one-cycle timeout-error pulse to owner
//  m_dat_r    out  DW    read data, valid with m_ack, held until next ack
//  s_cyc      out  1     slave bus cycle active
//  s_stb      out  1     slave strobe
//  s_we       out  1     slave write enable
//  s_adr      out  AW    slave address
//  s_dat_w    out  DW    slave write data
//  s_dat_r    in   DW    slave read data, sampled when s_ack=1
//  s_ack      in   1     slave acknowledge
//  timeout    out  1     one-cycle pulse coincident with any m_err pulse
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; owner=0; counter=0. All outputs 0:
//    m_ack, m_err, m_dat_r, s_cyc, s_stb, s_we, s_adr, s_dat_w, timeout.
//  - All outputs registered. States IDLE, OWNED, XFER, DONE.
//  - IDLE: on edge with comcyc=1, latch owner=gnt, go OWNED, s_cyc=1 next cycle.
//  - OWNED: comcyc=0 -> IDLE, s_cyc=0.
//    Else if m_stb[owner]=1: capture m_adr/m_dat_w/m_we of owner into s_*,
//    s_stb=1, counter=0, go XFER. Request-to-s_stb latency is one clock.
//  - XFER: s_ack=1 -> s_stb=0, m_dat_r<=s_dat_r (reads only; writes leave it),
//    m_ack[owner]=1, go DONE.
//  - XFER, no ack: counter increments each cycle.
//    When counter==TO_CYCLES-1 (the TO_CYCLES-th stb cycle): s_stb=0,
//    m_err[owner]=1, timeout=1, go DONE.
//  - Simultaneous ack and timeout expiry: ack wins, no error.
//  - XFER with comcyc=0: abort. s_stb=0, s_cyc=0 next cycle, no m_ack/m_err,
//    go IDLE. Slave ack on the abort edge is ignored.
//  - DONE: one-cycle turnaround; m_ack/m_err high for exactly this cycle.
//    Prevents re-sampling the owner's still-high m_stb. Next: OWNED if
//    comcyc=1, else IDLE with s_cyc=0.
//  - gnt is ignored except on the IDLE->OWNED edge. Owner changes only via
//    IDLE, i.e. after comcyc drops.
//  - m_stb/m_we/m_adr/m_dat_w of non-owners are ignored. Their m_ack/m_err
//    stay 0.
//  - s_adr/s_we/s_dat_w hold last value outside XFER. Only s_stb/s_cyc
//    qualify them.
//  - Counter width $clog2(TO_CYCLES); no wrap reachable.
// TESTING
//  1. rst=0 mid-XFER with s_stb=1 -> same-cycle s_stb=s_cyc=m_ack=m_err=0,
//     all outputs 0. Release -> IDLE.
//  2. gnt=2, comcyc=1, m_stb[2]=1, m_we[2]=1, adr=0x3C, dat=0xA5; ack 2 cycles
//     after s_stb -> s_adr=0x3C, s_dat_w=0xA5, s_we=1. m_ack=4'b0100 one cycle;
//     m_dat_r unchanged.
//  3. gnt=1 read, s_dat_r=0x5A with s_ack -> m_ack=4'b0010 and m_dat_r=0x5A in
//     the same cycle. Owner m_stb held -> next s_stb only after DONE.
//  4. TO_CYCLES=16, gnt=3, s_ack never -> s_stb high exactly 16 cycles, then
//     m_err=4'b1000 and timeout=1 for one cycle, m_ack=0.
//  5. s_ack on 16th stb cycle -> m_ack pulse, m_err=0, timeout=0.
//  6. comcyc drops mid-XFER while m_stb[0]=1 (non-owner, gnt=3) ->
//     s_stb/s_cyc 0 next cycle. No ack/err to any master. Master 0 never
//     driven onto bus.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Muxes the arbiter-granted master onto one slave bus; request-to-s_stb and s_ack-to-m_ack are one clock each.
// Backpressure: s_stb is held until s_ack, a TO_CYCLES timeout (m_err) or loss of comcyc; DONE blocks re-sampling of a held m_stb.
module bus_xfer_ctrl #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned TO_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            comcyc_i,
  input  logic [1:0]      gnt_i,
  input  logic [3:0]      m_stb_i,
  input  logic [3:0]      m_we_i,
  input  logic [4*AW-1:0] m_adr_i,
  input  logic [4*DW-1:0] m_dat_w_i,
  output logic [3:0]      m_ack_o,
  output logic [3:0]      m_err_o,
  output logic [DW-1:0]   m_dat_r_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_w_o,
  input  logic [DW-1:0]   s_dat_r_i,
  input  logic            s_ack_i,
  output logic            timeout_o
);

  localparam int unsigned CW = $clog2(TO_CYCLES);

  typedef enum logic [1:0] {IDLE, OWNED, XFER, DONE} state_e;

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      m_ack_q, m_ack_d;
  logic [3:0]      m_err_q, m_err_d;
  logic [DW-1:0]   m_dat_r_q, m_dat_r_d;
  logic            s_cyc_q, s_cyc_d;
  logic            s_stb_q, s_stb_d;
  logic            s_we_q, s_we_d;
  logic [AW-1:0]   s_adr_q, s_adr_d;
  logic [DW-1:0]   s_dat_w_q, s_dat_w_d;
  logic            timeout_q, timeout_d;

  logic            owner_stb;
  logic [3:0]      owner_oh;
  logic            ack_hit;
  logic            expired;

  assign owner_stb = m_stb_i[owner_q];
  assign owner_oh  = 4'b0001 << owner_q;
  assign ack_hit   = comcyc_i && s_ack_i;
  // An ack on the final strobe cycle takes precedence over the timeout.
  assign expired   = comcyc_i && !s_ack_i && (cnt_q == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      cnt_q     <= '0;
      m_ack_q   <= '0;
      m_err_q   <= '0;
      m_dat_r_q <= '0;
      s_cyc_q   <= 1'b0;
      s_stb_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_adr_q   <= '0;
      s_dat_w_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      m_ack_q   <= m_ack_d;
      m_err_q   <= m_err_d;
      m_dat_r_q <= m_dat_r_d;
      s_cyc_q   <= s_cyc_d;
      s_stb_q   <= s_stb_d;
      s_we_q    <= s_we_d;
      s_adr_q   <= s_adr_d;
      s_dat_w_q <= s_dat_w_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (comcyc_i) begin
          state_d = OWNED;
          owner_d = gnt_i;
        end
      end
      OWNED: begin
        if (!comcyc_i) begin
          state_d = IDLE;
        end else if (owner_stb) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (!comcyc_i) begin
          state_d = IDLE;
        end else if (ack_hit || expired) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = comcyc_i ? OWNED : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    m_ack_d   = '0;
    m_err_d   = '0;
    timeout_d = 1'b0;
    m_dat_r_d = m_dat_r_q;
    s_cyc_d   = (state_d != IDLE);
    s_stb_d   = (state_d == XFER);
    s_we_d    = s_we_q;
    s_adr_d   = s_adr_q;
    s_dat_w_d = s_dat_w_q;
    if (state_q == OWNED && state_d == XFER) begin
      s_we_d    = m_we_i[owner_q];
      s_adr_d   = m_adr_i[owner_q*AW +: AW];
      s_dat_w_d = m_dat_w_i[owner_q*DW +: DW];
    end
    if (state_q == XFER && state_d == DONE) begin
      if (ack_hit) begin
        m_ack_d = owner_oh;
        if (!s_we_q) m_dat_r_d = s_dat_r_i;
      end else begin
        m_err_d   = owner_oh;
        timeout_d = 1'b1;
      end
    end
  end

  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_dat_r_o = m_dat_r_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign s_we_o    = s_we_q;
  assign s_adr_o   = s_adr_q;
  assign s_dat_w_o = s_dat_w_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: directed vector table, corner-case sequences and
// randomized transactions predicted by a transaction-level model.
module tb_bus_xfer_ctrl;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            comcyc_i;
  logic [1:0]      gnt_i;
  logic [3:0]      m_stb_i, m_we_i;
  logic [4*AW-1:0] m_adr_i;
  logic [4*DW-1:0] m_dat_w_i;
  logic [3:0]      m_ack_o, m_err_o;
  logic [DW-1:0]   m_dat_r_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_w_o;
  logic [DW-1:0]   s_dat_r_i;
  logic            s_ack_i;
  logic            timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] model_dat;

  bus_xfer_ctrl #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .comcyc_i(comcyc_i), .gnt_i(gnt_i),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_w_i(m_dat_w_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_r_o(m_dat_r_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_w_o(s_dat_w_o), .s_dat_r_i(s_dat_r_i), .s_ack_i(s_ack_i), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] g;
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
    int         ack_at;
    logic [7:0] rdata;
    int         e_stb;
    logic [3:0] e_ack;
    logic [3:0] e_err;
    logic       e_tmo;
    logic [7:0] e_dat_r;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [35:0] all_outs();
    return {m_ack_o, m_err_o, m_dat_r_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_w_o, timeout_o};
  endfunction

  // One full ownership session: grant, one transfer, release. Non-owners request with other values.
  task automatic run_xfer(input logic [1:0] g, input logic we, input logic [7:0] adr,
                          input logic [7:0] dat, input int ack_at, input logic [7:0] rdata,
                          output int stb_n, output logic [3:0] ack_v, output logic [3:0] err_v,
                          output logic tmo, output logic [7:0] dat_r, output logic [7:0] sadr,
                          output logic [7:0] sdat, output logic swe);
    bit done;
    comcyc_i = 1'b1;
    gnt_i    = g;
    m_stb_i  = ~(4'b0001 << g);
    for (int i = 0; i < 4; i++) begin
      m_adr_i[i*AW +: AW]   = ~adr;
      m_dat_w_i[i*DW +: DW] = ~dat;
      m_we_i[i]             = ~we;
    end
    tick();
    chk("s_cyc_after_grant", s_cyc_o, 1);
    m_stb_i              = 4'hF;
    m_adr_i[g*AW +: AW]   = adr;
    m_dat_w_i[g*DW +: DW] = dat;
    m_we_i[g]             = we;
    tick();
    sadr = s_adr_o; sdat = s_dat_w_o; swe = s_we_o;
    stb_n = 0; done = 0; ack_v = '0; err_v = '0; tmo = 1'b0; dat_r = '0;
    for (int k = 1; k <= TO + 4 && !done; k++) begin
      if (s_stb_o) stb_n++;
      s_ack_i   = (k == ack_at);
      s_dat_r_i = (k == ack_at) ? rdata : 8'($urandom);
      tick();
      if (m_ack_o != 0 || m_err_o != 0) begin
        done = 1; ack_v = m_ack_o; err_v = m_err_o; tmo = timeout_o; dat_r = m_dat_r_o;
      end
    end
    chk("xfer_completed", done, 1);
    s_ack_i = 1'b0; m_stb_i = '0; comcyc_i = 1'b0;
    tick();
    chk("pulse_one_cycle", {m_ack_o, m_err_o, timeout_o}, 0);
    chk("bus_released", {s_cyc_o, s_stb_o}, 0);
    chk("s_adr_held", s_adr_o, adr);
  endtask

  initial begin
    int         stb_n;
    logic [3:0] ack_v, err_v;
    logic       tmo, swe;
    logic [7:0] dat_r, sadr, sdat;

    tbl[0] = '{2'd2, 1'b1, 8'h3C, 8'hA5,  3, 8'hEE,  3, 4'b0100, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{2'd1, 1'b0, 8'h11, 8'h22,  1, 8'h5A,  1, 4'b0010, 4'b0000, 1'b0, 8'h5A};
    tbl[2] = '{2'd3, 1'b0, 8'h44, 8'h55,  0, 8'h99, 16, 4'b0000, 4'b1000, 1'b1, 8'h5A};
    tbl[3] = '{2'd0, 1'b0, 8'h66, 8'h77, 16, 8'hC3, 16, 4'b0001, 4'b0000, 1'b0, 8'hC3};
    tbl[4] = '{2'd2, 1'b1, 8'h88, 8'h99, 16, 8'hFF, 16, 4'b0100, 4'b0000, 1'b0, 8'hC3};
    tbl[5] = '{2'd0, 1'b1, 8'hFE, 8'h01, 15, 8'h12, 15, 4'b0001, 4'b0000, 1'b0, 8'hC3};
    tbl[6] = '{2'd1, 1'b0, 8'h00, 8'hFF,  2, 8'h00,  2, 4'b0010, 4'b0000, 1'b0, 8'h00};
    tbl[7] = '{2'd3, 1'b0, 8'hAB, 8'hCD, 17, 8'h34, 16, 4'b0000, 4'b1000, 1'b1, 8'h00};

    rst_ni = 1'b0; comcyc_i = 1'b0; gnt_i = '0; m_stb_i = '0; m_we_i = '0;
    m_adr_i = '0; m_dat_w_i = '0; s_dat_r_i = '0; s_ack_i = 1'b0;
    tick(); tick();
    chk("reset_outputs_zero", all_outs(), 0);
    rst_ni = 1'b1;
    tick();
    chk("idle_after_reset", all_outs(), 0);

    for (int v = 0; v < 8; v++) begin
      run_xfer(tbl[v].g, tbl[v].we, tbl[v].adr, tbl[v].dat, tbl[v].ack_at, tbl[v].rdata,
               stb_n, ack_v, err_v, tmo, dat_r, sadr, sdat, swe);
      chk("tbl_s_adr", sadr, tbl[v].adr);
      chk("tbl_s_dat_w", sdat, tbl[v].dat);
      chk("tbl_s_we", swe, tbl[v].we);
      chk("tbl_stb_cycles", stb_n, tbl[v].e_stb);
      chk("tbl_m_ack", ack_v, tbl[v].e_ack);
      chk("tbl_m_err", err_v, tbl[v].e_err);
      chk("tbl_timeout", tmo, tbl[v].e_tmo);
      chk("tbl_m_dat_r", dat_r, tbl[v].e_dat_r);
    end
    model_dat = tbl[7].e_dat_r;

    // Owner keeps m_stb high through DONE: the next strobe must wait for OWNED.
    comcyc_i = 1'b1; gnt_i = 2'd1; m_stb_i = 4'b0010; m_we_i = 4'b0000;
    m_adr_i = '0; m_adr_i[AW +: AW] = 8'h21;
    tick();
    chk("held_owned_no_stb", s_stb_o, 0);
    tick();
    chk("held_stb_up", s_stb_o, 1);
    s_ack_i = 1'b1; s_dat_r_i = 8'h5A;
    tick();
    chk("held_ack", m_ack_o, 4'b0010);
    chk("held_dat_r_same_cycle", m_dat_r_o, 8'h5A);
    chk("held_stb_down", s_stb_o, 0);
    s_ack_i = 1'b0;
    tick();
    chk("held_turnaround_no_stb", {s_stb_o, m_ack_o}, 0);
    tick();
    chk("held_restrobe", s_stb_o, 1);
    s_ack_i = 1'b1; s_dat_r_i = 8'h6B;
    tick();
    chk("held_second_ack", {m_ack_o, m_dat_r_o}, {4'b0010, 8'h6B});
    s_ack_i = 1'b0; m_stb_i = '0; comcyc_i = 1'b0;
    tick();
    chk("held_release", s_cyc_o, 0);
    model_dat = 8'h6B;

    // comcyc drops mid-transfer with a coincident ack; master 0 requests but does not own.
    comcyc_i = 1'b1; gnt_i = 2'd3; m_stb_i = 4'b1001; m_we_i = 4'b0001;
    m_adr_i = {8'h3D, 8'h00, 8'h00, 8'h77};
    m_dat_w_i = {8'h4E, 8'h00, 8'h00, 8'h88};
    tick(); tick();
    chk("abort_owner_on_bus", {s_stb_o, s_we_o, s_adr_o, s_dat_w_o}, {1'b1, 1'b0, 8'h3D, 8'h4E});
    tick(); tick();
    comcyc_i = 1'b0; s_ack_i = 1'b1; s_dat_r_i = 8'hE7;
    tick();
    chk("abort_bus_down", {s_cyc_o, s_stb_o}, 0);
    chk("abort_no_pulse", {m_ack_o, m_err_o, timeout_o}, 0);
    chk("abort_dat_r_kept", m_dat_r_o, model_dat);
    s_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_quiet", {m_ack_o, m_err_o, s_stb_o, s_adr_o}, {9'd0, 8'h3D});
    end
    m_stb_i = '0;

    // Randomized sessions against a transaction-level expectation.
    for (int n = 0; n < 40; n++) begin
      logic [1:0] g;
      logic       we;
      logic [7:0] adr, dat, rd;
      int         ack_at, e_stb;
      bit         ok;
      g = 2'($urandom); we = 1'($urandom); adr = 8'($urandom); dat = 8'($urandom);
      rd = 8'($urandom); ack_at = $urandom_range(0, TO + 2);
      ok    = (ack_at >= 1 && ack_at <= TO);
      e_stb = ok ? ack_at : TO;
      if (ok && !we) model_dat = rd;
      run_xfer(g, we, adr, dat, ack_at, rd, stb_n, ack_v, err_v, tmo, dat_r, sadr, sdat, swe);
      chk("rnd_s_adr", sadr, adr);
      chk("rnd_s_dat_w", sdat, dat);
      chk("rnd_s_we", swe, we);
      chk("rnd_stb_cycles", stb_n, e_stb);
      chk("rnd_m_ack", ack_v, ok ? (4'b0001 << g) : 4'b0000);
      chk("rnd_m_err", err_v, ok ? 4'b0000 : (4'b0001 << g));
      chk("rnd_timeout", tmo, !ok);
      chk("rnd_m_dat_r", dat_r, model_dat);
    end

    // Asynchronous reset while the strobe is up, then recovery through IDLE.
    comcyc_i = 1'b1; gnt_i = 2'd0; m_stb_i = 4'b0001; m_we_i = 4'b0001;
    m_adr_i = '0; m_adr_i[0 +: AW] = 8'h5C; m_dat_w_i = '0; m_dat_w_i[0 +: DW] = 8'hC5;
    tick(); tick(); tick();
    chk("rst_pre_stb", s_stb_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_async_zero", all_outs(), 0);
    comcyc_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rst_release_idle", all_outs(), 0);
    comcyc_i = 1'b1;
    tick();
    chk("rst_regrant_owned", {s_cyc_o, s_stb_o}, 2'b10);
    tick();
    chk("rst_regrant_stb", {s_stb_o, s_adr_o}, {1'b1, 8'h5C});
    comcyc_i = 1'b0; m_stb_i = '0;
    tick();
    chk("rst_final_release", {s_cyc_o, s_stb_o, m_ack_o, m_err_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
